// File: rtl/mdio_slave_rx.sv
// MDIO management-frame slave: decodes Clause 22 frames (Clause 45 when
// MDIO_C45_EN is defined) on mdio_in, filters on PHY_ADDR, and produces
// register strobes or serial read data.
// Ports: MDC clock, rst sync active-low; mdio_in/mdio_out/mdio_oe serial
// line; rd_data in; rd_stb, wr_stb, addr, dev_addr, wr_data, mdio_done,
// frame_err out.
module mdio_slave_rx #(
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter int         PRE_BITS = 32
) (
  input  logic        MDC,
  input  logic        rst,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic [15:0] rd_data,
  output logic        rd_stb,
  output logic        wr_stb,
  output logic [15:0] addr,
  output logic [4:0]  dev_addr,
  output logic [15:0] wr_data,
  output logic        mdio_done,
  output logic        frame_err
);

  typedef enum logic [3:0] {
    S_PRE, S_ST, S_OP, S_PHY, S_REG,
    S_TA, S_WDAT, S_RDAT, S_SKIP
  } state_t;

  localparam logic [5:0] PRE_MAX = 6'(PRE_BITS);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d, cnt_inc;
  logic [15:0] sh_q, sh_d, word;
  logic [1:0]  bits2;
  logic [4:0]  bits5;
  logic        match_q, match_d;
  logic        is_rd_q, is_rd_d;
  logic        out_q, out_d;
  logic        oe_q, oe_d;
  logic        rd_stb_q, rd_stb_d;
  logic        wr_stb_q, wr_stb_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] wr_data_q, wr_data_d;
`ifdef MDIO_C45_EN
  logic        c45_q, c45_d;
  logic        is_addr_q, is_addr_d;
  logic        is_inc_q, is_inc_d;
  logic [15:0] areg_q, areg_d;
  logic [15:0] addr_q, addr_d;
  logic [4:0]  dev_q, dev_d;
  assign addr     = addr_q;
  assign dev_addr = dev_q;
`else
  logic [4:0]  addr_q, addr_d;
  assign addr     = {11'd0, addr_q};
  assign dev_addr = 5'd0;
`endif

  assign mdio_out  = out_q;
  assign mdio_oe   = oe_q;
  assign rd_stb    = rd_stb_q;
  assign wr_stb    = wr_stb_q;
  assign wr_data   = wr_data_q;
  assign mdio_done = done_q;
  assign frame_err = err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    match_d   = match_q;
    is_rd_d   = is_rd_q;
    out_d     = out_q;
    oe_d      = oe_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rd_stb_d  = 1'b0;
    wr_stb_d  = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef MDIO_C45_EN
    c45_d     = c45_q;
    is_addr_d = is_addr_q;
    is_inc_d  = is_inc_q;
    areg_d    = areg_q;
    dev_d     = dev_q;
`endif
    cnt_inc = cnt_q + 6'd1;
    bits2   = {sh_q[0], mdio_in};
    bits5   = {sh_q[3:0], mdio_in};
    word    = {sh_q[14:0], mdio_in};

    unique case (state_q)
      S_PRE: begin
        if (mdio_in) begin
          cnt_d = (cnt_q == PRE_MAX) ? cnt_q : cnt_inc;
        end else if (cnt_q == PRE_MAX) begin
          // this 0 is the first start bit
          cnt_d   = '0;
          state_d = S_ST;
        end else begin
          cnt_d = '0;
        end
      end
      S_ST: begin
        cnt_d = '0;
        if (mdio_in) begin
          state_d = S_OP;
`ifdef MDIO_C45_EN
          c45_d = 1'b0;
`endif
        end else begin
`ifdef MDIO_C45_EN
          c45_d   = 1'b1;
          state_d = S_OP;
`else
          err_d   = 1'b1;
          state_d = S_PRE;
`endif
        end
      end
      S_OP: begin
        sh_d  = word;
        cnt_d = cnt_inc;
        if (cnt_q == 6'd1) begin
          cnt_d   = '0;
          state_d = S_PHY;
`ifdef MDIO_C45_EN
          is_addr_d = 1'b0;
          is_inc_d  = 1'b0;
          if (c45_q) begin
            is_rd_d   = bits2[1];
            is_addr_d = (bits2 == 2'b00);
            is_inc_d  = (bits2 == 2'b10);
          end else
`endif
          if (bits2[1] ^ bits2[0]) begin
            is_rd_d = bits2[1];
          end else begin
            err_d   = 1'b1;
            state_d = S_PRE;
          end
        end
      end
      S_PHY: begin
        sh_d  = word;
        cnt_d = cnt_inc;
        if (cnt_q == 6'd4) begin
          cnt_d   = '0;
          match_d = (bits5 == PHY_ADDR);
          state_d = S_REG;
        end
      end
      S_REG: begin
        sh_d  = word;
        cnt_d = cnt_inc;
        if (cnt_q == 6'd4) begin
          cnt_d = '0;
          if (match_q) begin
            state_d  = S_TA;
            rd_stb_d = is_rd_q;
`ifdef MDIO_C45_EN
            if (c45_q) begin
              addr_d = areg_q;
              dev_d  = bits5;
            end else begin
              addr_d = {11'd0, bits5};
              dev_d  = 5'd0;
            end
`else
            addr_d = bits5;
`endif
          end else begin
            state_d = S_SKIP;
          end
        end
      end
      S_TA: begin
        cnt_d = cnt_inc;
        if (is_rd_q) begin
          if (cnt_q == 6'd0) begin
            sh_d  = rd_data;
            out_d = 1'b0;
            oe_d  = 1'b1;
          end else begin
            out_d   = sh_q[15];
            sh_d    = {sh_q[14:0], 1'b0};
            cnt_d   = '0;
            state_d = S_RDAT;
          end
        end else if (mdio_in != (cnt_q == 6'd0)) begin
          // master must drive 1 then 0
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_PRE;
        end else if (cnt_q != 6'd0) begin
          cnt_d   = '0;
          state_d = S_WDAT;
        end
      end
      S_RDAT: begin
        cnt_d = cnt_inc;
        if (cnt_q == 6'd15) begin
          out_d   = 1'b0;
          oe_d    = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_PRE;
`ifdef MDIO_C45_EN
          if (is_inc_q) areg_d = areg_q + 16'd1;
`endif
        end else begin
          out_d = sh_q[15];
          sh_d  = {sh_q[14:0], 1'b0};
        end
      end
      S_WDAT: begin
        sh_d  = word;
        cnt_d = cnt_inc;
        if (cnt_q == 6'd15) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_PRE;
`ifdef MDIO_C45_EN
          if (is_addr_q) begin
            areg_d = word;
          end else
`endif
          begin
            wr_data_d = word;
            wr_stb_d  = 1'b1;
          end
        end
      end
      S_SKIP: begin
        cnt_d = cnt_inc;
        if (cnt_q == 6'd17) begin
          cnt_d   = '0;
          state_d = S_PRE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_PRE;
      end
    endcase
  end

  always_ff @(posedge MDC) begin
    if (!rst) begin
      state_q   <= S_PRE;
      cnt_q     <= '0;
      sh_q      <= '0;
      match_q   <= 1'b0;
      is_rd_q   <= 1'b0;
      out_q     <= 1'b0;
      oe_q      <= 1'b0;
      rd_stb_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
`ifdef MDIO_C45_EN
      c45_q     <= 1'b0;
      is_addr_q <= 1'b0;
      is_inc_q  <= 1'b0;
      areg_q    <= '0;
      dev_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      match_q   <= match_d;
      is_rd_q   <= is_rd_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      rd_stb_q  <= rd_stb_d;
      wr_stb_q  <= wr_stb_d;
      done_q    <= done_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
`ifdef MDIO_C45_EN
      c45_q     <= c45_d;
      is_addr_q <= is_addr_d;
      is_inc_q  <= is_inc_d;
      areg_q    <= areg_d;
      dev_q     <= dev_d;
`endif
    end
  end

endmodule
